// File: rtl/boneless_ext_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : boneless_ext_uart
//  Purpose  : 8N1 UART responder on the Boneless ext bus; 4-register window
//             (DATA, STAT, DIV, CTRL) with a TX FIFO and an RX holding register.
//  Options  : UART_LOOPBACK_EN enables CTRL.LOOP (TX shift output -> RX path).
//  Revision : 1.0 - initial release
// ============================================================================
module boneless_ext_uart #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd103
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ext_adr,
    input  logic        ext_re,
    input  logic        ext_we,
    input  logic [15:0] ext_dat_w,
    output logic [15:0] ext_dat_r,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int         c_AW    = $clog2(TX_DEPTH);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic        w_sel, w_rd, w_wr, w_rd_data, w_push_req, w_push, w_pop;
    logic        w_empty, w_full, w_tx_tick, w_tx_line, w_rx_tick, w_rx_done;
    logic        w_rx_in, w_rx_fall, w_loop;
    logic [1:0]  w_tx_next, w_rx_next;
    logic [15:0] w_half, w_rd_mux;

    logic [7:0]      r_fifo [TX_DEPTH];
    logic [c_AW:0]   r_wptr, r_rptr;
    logic [1:0]      r_tx_state, r_rx_state;
    logic [15:0]     r_tx_timer, r_rx_timer, r_div;
    logic [2:0]      r_tx_bit, r_rx_bit;
    logic [7:0]      r_tx_shift, r_rx_shift, r_rx_byte;
    logic            r_rx_s1, r_rx_s2, r_rx_s3;
    logic            r_rx_valid, r_rx_ovr, r_tx_ovf, r_rx_ferr;

    assign w_sel      = (ext_adr[15:2] == BASE_ADDR[15:2]);
    assign w_rd       = ext_re & w_sel;
    assign w_wr       = ext_we & w_sel;
    assign w_rd_data  = w_rd && (ext_adr[1:0] == 2'd0);
    assign w_push_req = w_wr && (ext_adr[1:0] == 2'd0);
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign w_push     = w_push_req && (!w_full || w_pop);

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

`ifdef UART_LOOPBACK_EN
    logic r_loop;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_loop <= 1'b0;
        else if (w_wr && ext_adr[1:0] == 2'd3)   r_loop <= ext_dat_w[0];
    end
    assign w_loop  = r_loop;
    assign w_rx_in = r_loop ? w_tx_line : uart_rx;
`else
    assign w_loop  = 1'b0;
    assign w_rx_in = uart_rx;
`endif

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr[c_AW-1:0]] <= ext_dat_w[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    assign w_tx_tick = (r_tx_timer == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tx_state <= c_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_pop     = 1'b0;
        case (r_tx_state)
            c_IDLE:  if (!w_empty) begin w_pop = 1'b1; w_tx_next = c_START; end
            c_START: if (w_tx_tick) w_tx_next = c_DATA;
            c_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = c_STOP;
            c_STOP:  if (w_tx_tick) begin
                         if (!w_empty) begin w_pop = 1'b1; w_tx_next = c_START; end
                         else          w_tx_next = c_IDLE;
                     end
            default: w_tx_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_tx_line = 1'b1;
        case (r_tx_state)
            c_START: w_tx_line = 1'b0;
            c_DATA:  w_tx_line = r_tx_shift[0];
            default: w_tx_line = 1'b1;
        endcase
    end

    assign uart_tx = w_loop ? 1'b1 : w_tx_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_timer <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else if (w_pop) begin
            r_tx_shift <= r_fifo[r_rptr[c_AW-1:0]];
            r_tx_timer <= r_div;
            r_tx_bit   <= '0;
        end else if (r_tx_state != c_IDLE) begin
            if (w_tx_tick) begin
                r_tx_timer <= r_div;
                if (r_tx_state == c_DATA) begin
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    r_tx_bit   <= r_tx_bit + 3'd1;
                end
            end else begin
                r_tx_timer <= r_tx_timer - 16'd1;
            end
        end
    end

    // ---------------- RX FSM ----------------
    assign w_half    = {1'b0, r_div[15:1]};
    assign w_rx_tick = (r_rx_timer == 16'd0);
    assign w_rx_fall = r_rx_s3 && !r_rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= c_IDLE;
        end else begin
            r_rx_s1    <= w_rx_in;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_state <= w_rx_next;
        end
    end

    // With a zero half-period the start bit is sampled in the detection cycle itself.
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_done = 1'b0;
        case (r_rx_state)
            c_IDLE:  if (w_rx_fall) w_rx_next = (w_half == 16'd0) ? c_DATA : c_START;
            c_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? c_IDLE : c_DATA;
            c_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = c_STOP;
            c_STOP:  if (w_rx_tick) begin w_rx_done = 1'b1; w_rx_next = c_IDLE; end
            default: w_rx_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_timer <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else if (r_rx_state == c_IDLE) begin
            if (w_rx_fall) begin
                r_rx_timer <= (w_half == 16'd0) ? r_div : w_half - 16'd1;
                r_rx_bit   <= '0;
            end
        end else if (w_rx_tick) begin
            r_rx_timer <= r_div;
            if (r_rx_state == c_DATA) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end else begin
            r_rx_timer <= r_rx_timer - 16'd1;
        end
    end

    // ---------------- registers and flags ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_div      <= DIV_RESET;
        end else begin
            if (w_rx_done) begin
                r_rx_byte  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (w_rd_data) begin
                r_rx_valid <= 1'b0;
            end
            if (w_rx_done && r_rx_valid && !w_rd_data)        r_rx_ovr <= 1'b1;
            else if (w_wr && ext_adr[1:0] == 2'd1 && ext_dat_w[3]) r_rx_ovr <= 1'b0;
            if (w_rx_done && !r_rx_s2)                        r_rx_ferr <= 1'b1;
            else if (w_wr && ext_adr[1:0] == 2'd1 && ext_dat_w[6]) r_rx_ferr <= 1'b0;
            if (w_push_req && !w_push)                        r_tx_ovf <= 1'b1;
            else if (w_wr && ext_adr[1:0] == 2'd1 && ext_dat_w[4]) r_tx_ovf <= 1'b0;
            if (w_wr && ext_adr[1:0] == 2'd2)                 r_div <= ext_dat_w;
        end
    end

    always_comb begin
        w_rd_mux = 16'h0000;
        case (ext_adr[1:0])
            2'd0: w_rd_mux = {8'h00, r_rx_byte};
            2'd1: w_rd_mux = {9'd0, r_rx_ferr, (r_tx_state != c_IDLE), r_tx_ovf,
                              r_rx_ovr, r_rx_valid, w_empty, w_full};
            2'd2: w_rd_mux = r_div;
            default: w_rd_mux = {15'd0, w_loop};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ext_dat_r <= 16'h0000;
        else if (w_rd) ext_dat_r <= w_rd_mux;
    end

endmodule
`default_nettype wire

// File: tb/tb_boneless_ext_uart.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_boneless_ext_uart
//  Purpose  : Directed scoreboard bench for boneless_ext_uart (DIV=3 timing).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_boneless_ext_uart;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ext_adr = '0;
    logic        ext_re = 1'b0;
    logic        ext_we = 1'b0;
    logic [15:0] ext_dat_w = '0;
    logic [15:0] ext_dat_r;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb_q[$];

    boneless_ext_uart dut (
        .clk(clk), .rst_n(rst_n), .ext_adr(ext_adr), .ext_re(ext_re),
        .ext_we(ext_we), .ext_dat_w(ext_dat_w), .ext_dat_r(ext_dat_r),
        .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input logic [15:0] v);
        sb_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=%h required=<scoreboard entry>", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed=%h required=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic wr(input logic [15:0] adr, input logic [15:0] dat);
        @(negedge clk);
        ext_adr = adr; ext_dat_w = dat; ext_we = 1'b1;
        @(negedge clk);
        ext_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] adr, input logic [15:0] exp);
        @(negedge clk);
        ext_adr = adr; ext_re = 1'b1;
        expect_val(exp);
        @(negedge clk);
        ext_re = 1'b0;
        check(tag, ext_dat_r);
    endtask

    // Samples each bit two cycles into its four-cycle period.
    task automatic tx_frame(input string tag, input logic [7:0] b);
        logic [9:0] bits;
        bit         found;
        int         pos;
        bits  = {1'b1, b, 1'b0};
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) found = 1;
        end
        expect_val(16'h0000);
        check({tag, "_start"}, {15'd0, uart_tx});
        pos = 0;
        for (int i = 1; i < 10; i++) begin
            repeat (4 * i + 2 - pos) @(negedge clk);
            pos = 4 * i + 2;
            expect_val({15'd0, bits[i]});
            check($sformatf("%s_bit%0d", tag, i), {15'd0, uart_tx});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int tx_lows;

        // Reset state
        repeat (3) @(negedge clk);
        expect_val(16'h0001); check("reset_uart_tx", {15'd0, uart_tx});
        expect_val(16'h0000); check("reset_dat_r", ext_dat_r);
        rst_n = 1'b1;
        rd("stat_reset", 16'h0001, 16'h0002);

        // Divisor, window decode
        wr(16'h0002, 16'h0003);
        rd("div_rb", 16'h0002, 16'h0003);
        rd("unsel_read_holds", 16'h0005, 16'h0003);
        wr(16'h0006, 16'h00FF);
        rd("unsel_write_ignored", 16'h0002, 16'h0003);

`ifdef UART_LOOPBACK_EN
        rd("ctrl_reset", 16'h0003, 16'h0000);
`else
        wr(16'h0003, 16'h0001);
        rd("reg3_reads_zero", 16'h0003, 16'h0000);
`endif

        // Single byte transmit
        wr(16'h0000, 16'h00A5);
        tx_frame("txA5", 8'hA5);
        rd("stat_tx_done", 16'h0001, 16'h0002);

        // FIFO fill and overflow
        for (int i = 0; i < 5; i++) wr(16'h0000, 16'h0010 + 16'(i));
        rd("stat_fifo_full", 16'h0001, 16'h0021);
        wr(16'h0000, 16'h0099);
        rd("stat_tx_ovf", 16'h0001, 16'h0031);
        wr(16'h0001, 16'h0010);
        rd("stat_ovf_w1c", 16'h0001, 16'h0021);
        repeat (260) @(negedge clk);
        rd("stat_drained", 16'h0001, 16'h0002);

        // Receive
        rx_send(8'h3C, 1'b1);
        rd("stat_rx_valid", 16'h0001, 16'h0006);
        rd("rx_data_3c", 16'h0000, 16'h003C);
        rd("stat_rx_cleared", 16'h0001, 16'h0002);
        rx_send(8'hA1, 1'b1);
        rx_send(8'h5E, 1'b1);
        rd("stat_rx_ovr", 16'h0001, 16'h000E);
        rd("rx_data_5e", 16'h0000, 16'h005E);
        wr(16'h0001, 16'h0008);
        rd("stat_ovr_w1c", 16'h0001, 16'h0002);

        // Glitch and framing error
        @(negedge clk); uart_rx = 1'b0;
        @(negedge clk); uart_rx = 1'b1;
        repeat (12) @(negedge clk);
        rd("stat_glitch", 16'h0001, 16'h0002);
        rx_send(8'h55, 1'b0);
        rd("stat_ferr", 16'h0001, 16'h0046);
        rd("rx_data_55", 16'h0000, 16'h0055);
        wr(16'h0001, 16'h0040);
        rd("stat_ferr_w1c", 16'h0001, 16'h0002);

`ifdef UART_LOOPBACK_EN
        wr(16'h0003, 16'h0001);
        rd("ctrl_loop", 16'h0003, 16'h0001);
        wr(16'h0000, 16'h0081);
        tx_lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) tx_lows++;
        end
        expect_val(16'h0000); check("loop_tx_idle", 16'(tx_lows));
        rd("loop_data", 16'h0000, 16'h0081);
        wr(16'h0003, 16'h0000);
`else
        tx_lows = 0;
`endif

        // Reset in the middle of a frame
        wr(16'h0000, 16'h0000);
        wr(16'h0000, 16'h0033);
        repeat (8) @(negedge clk);
        expect_val(16'h0000); check("midframe_low", {15'd0, uart_tx});
        #2 rst_n = 1'b0;
        #1;
        expect_val(16'h0001); check("midframe_reset_tx", {15'd0, uart_tx});
        expect_val(16'h0000); check("midframe_reset_dat_r", ext_dat_r);
        @(negedge clk); rst_n = 1'b1;
        rd("stat_after_reset", 16'h0001, 16'h0002);
        rd("div_after_reset", 16'h0002, 16'h0067);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
